// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and display/status outputs of the stopwatch core (optional split: STOPWATCH_SPLIT_EN).
// Latency: pure wiring, no registers.
// Backpressure: none; outputs are level/pulse signals sampled every cycle by the consumer.
interface stopwatch_ctrl_if #(
   parameter int DIGITS = 4
);
   logic [3:0]          btn;
   logic [4*DIGITS-1:0] count_bcd;
   logic [4*DIGITS-1:0] display_bcd;
   logic                frozen;
   logic [3:0]          led;
   logic                tick;
   logic                ovf;

   modport master (
      input  btn,
      output count_bcd, display_bcd, frozen, led, tick, ovf
   );

   modport slave (
      output btn,
      input  count_bcd, display_bcd, frozen, led, tick, ovf
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch core: debounced buttons, one-hot RESET/RUN/SPLIT/STOP FSM, BCD count, split snapshot (STOPWATCH_SPLIT_EN).
// Latency: a button release acts on the 3rd rising edge; every output is registered.
// Backpressure: none; the display decoder consumes outputs every cycle.
module stopwatch_ctrl #(
   parameter int TICK_DIV   = 5000000,
   parameter int DIGITS     = 4,
   parameter int DEB_CYCLES = 1000
) (
   input  logic             clk,
   input  logic             rst,
   stopwatch_ctrl_if.master sw
);

`ifdef STOPWATCH_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif
   localparam int PW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam int CW = 4 * DIGITS;

   typedef enum logic [3:0] {
      S_RESET = 4'b1000,
      S_RUN   = 4'b0100,
      S_SPLIT = 4'b0010,
      S_STOP  = 4'b0001
   } state_t;

   // Release events, one per button: [0] stop, [1] split, [2] start, [3] reset.
   logic [3:0] ev;

   for (genvar i = 0; i < 4; i++) begin : g_btn
      if (i != 1 || SPLIT_EN) begin : g_deb
         logic          s1;
         logic          s2;
         logic [DW-1:0] cnt;
         logic          armed;

         assign armed = (cnt == DW'(DEB_CYCLES));
         assign ev[i] = s2 & armed;

         // Synchronize the button (idle high), then count consecutive lows, saturating once armed.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s1  <= 1'b1;
               s2  <= 1'b1;
               cnt <= '0;
            end else begin
               s1 <= sw.btn[i];
               s2 <= s1;
               if (s2)
                  cnt <= '0;
               else if (!armed)
                  cnt <= cnt + 1'b1;
            end
         end
      end else begin : g_nodeb
         logic unused_btn;
         assign unused_btn = sw.btn[i];
         assign ev[i]      = 1'b0;
      end
   end

   state_t        state;
   state_t        state_nx;
   logic          clear;
   logic [PW-1:0] presc;
   logic [PW-1:0] presc_nx;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nx;
   logic [CW-1:0] count_inc;
   logic          wrap;
   logic          tick;
   logic          tick_nx;
   logic          ovf;
   logic          ovf_nx;
`ifdef STOPWATCH_SPLIT_EN
   logic          capture;
`endif

   // Next state from the highest-priority event: reset > stop > start > split.
   always_comb begin
      state_nx = state;
      clear    = 1'b0;
`ifdef STOPWATCH_SPLIT_EN
      capture  = 1'b0;
`endif
      if (ev[3]) begin
         state_nx = S_RESET;
         clear    = 1'b1;
      end else if (ev[0]) begin
         if (state != S_RESET)
            state_nx = S_STOP;
      end else if (ev[2]) begin
         state_nx = S_RUN;
      end else if (ev[1]) begin
         if (state == S_RUN || state == S_SPLIT) begin
            state_nx = S_SPLIT;
`ifdef STOPWATCH_SPLIT_EN
            capture  = 1'b1;
`endif
         end
      end
   end

   // Decimal increment of the count; wrap flags the all-9s to zero rollover.
   always_comb begin
      logic carry;
      carry     = 1'b1;
      count_inc = count;
      for (int d = 0; d < DIGITS; d++) begin
         if (carry) begin
            if (count[4*d +: 4] == 4'd9) begin
               count_inc[4*d +: 4] = 4'd0;
            end else begin
               count_inc[4*d +: 4] = count[4*d +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
      wrap = carry;
   end

   // Prescaler runs in RUN/SPLIT, holds in STOP/RESET; a reset event clears and suppresses the tick.
   always_comb begin
      presc_nx = presc;
      count_nx = count;
      tick_nx  = 1'b0;
      ovf_nx   = 1'b0;
      if (clear) begin
         presc_nx = '0;
         count_nx = '0;
      end else if (state == S_RUN || state == S_SPLIT) begin
         if (presc == PW'(TICK_DIV - 1)) begin
            presc_nx = '0;
            count_nx = count_inc;
            tick_nx  = 1'b1;
            ovf_nx   = wrap;
         end else begin
            presc_nx = presc + 1'b1;
         end
      end
   end

   // State, prescaler, count and pulse outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_RESET;
         presc <= '0;
         count <= '0;
         tick  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nx;
         presc <= presc_nx;
         count <= count_nx;
         tick  <= tick_nx;
         ovf   <= ovf_nx;
      end
   end

   assign sw.count_bcd = count;
   assign sw.tick      = tick;
   assign sw.ovf       = ovf;

`ifdef STOPWATCH_SPLIT_EN
   logic [CW-1:0] snap;
   logic [CW-1:0] snap_nx;
   logic [CW-1:0] display;
   logic          frozen;
   logic          frozen_nx;

   // Snapshot takes the pre-increment count on a split; display follows the next-state view.
   always_comb begin
      snap_nx = snap;
      if (clear)
         snap_nx = '0;
      else if (capture)
         snap_nx = count;
      frozen_nx = (state_nx == S_SPLIT);
   end

   // Snapshot and registered display path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap    <= '0;
         frozen  <= 1'b0;
         display <= '0;
      end else begin
         snap    <= snap_nx;
         frozen  <= frozen_nx;
         display <= frozen_nx ? snap_nx : count_nx;
      end
   end

   assign sw.frozen      = frozen;
   assign sw.display_bcd = display;
   assign sw.led         = state;
`else
   assign sw.frozen      = 1'b0;
   assign sw.display_bcd = count;
   assign sw.led         = {state[3], state[2], 1'b0, state[0]};
`endif

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Parametrised stopwatch core: debounces four active-low push-buttons, runs a one-hot RESET/RUN/SPLIT/STOP state machine, and keeps a BCD elapsed-time count of configurable digit width, advanced by a configurable prescaler. It provides a live count and a display value that can be frozen for split times, with overflow signalling. It sits between the board buttons/LEDs and the seven-segment decoder, which consumes `display_bcd` and `frozen`.

## Interface
- `TICK_DIV`, 5000000: clock cycles per count increment (0.1 s at 50 MHz); must be ≥2.
- `DIGITS`, 4: number of BCD digits in the count; must be 1..8.
- `DEB_CYCLES`, 1000: consecutive synchronized low samples required to arm a button; must be ≥1.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `btn` in 4: active-low buttons. `btn[0]` is stop, `btn[1]` is split, `btn[2]` is start, `btn[3]` is reset.
- `count_bcd` out 4*DIGITS: live BCD count. Digit 0 is in `[3:0]` and is the least significant.
- `display_bcd` out 4*DIGITS: value for the display. It equals either `count_bcd` or the split snapshot.
- `frozen` out 1: high while `display_bcd` shows the split snapshot.
- `led` out 4: one-hot state. RESET is `1000`, RUN is `0100`, SPLIT is `0010`, STOP is `0001`.
- `tick` out 1: one-cycle pulse on every count increment.
- `ovf` out 1: one-cycle pulse when the count wraps from all-9s to 0.

## Operation
- **Reset values.** Reset forces state RESET and sets `led=1000`. Count, snapshot, prescaler and debouncers go to 0. `frozen`, `tick` and `ovf` are 0.
- **Buttons.**
  - Each `btn[i]` passes through a 2-flop synchronizer.
  - A per-button counter arms the button after DEB_CYCLES consecutive synchronized-low samples.
  - A synchronized high on an armed button produces one release event and disarms the button.
  - A synchronized high before arming clears the counter without producing an event.
- **Simultaneous events.** Priority is reset > stop > start > split; the lower-priority events are discarded.
- **State transitions:**
  - Reset event: any state goes to RESET. Count, prescaler and snapshot are cleared.
  - Start event: RESET, STOP or SPLIT goes to RUN. A start event in RUN has no effect.
  - Stop event: any state except RESET goes to STOP. A stop event in RESET has no effect.
  - Split event in RUN: go to SPLIT; the snapshot takes the current `count_bcd`.
  - Split event in SPLIT: stay in SPLIT; the snapshot is recaptured.
  - Split event in RESET or STOP: no effect.
- **Prescaler.** Runs 0..TICK_DIV-1 in RUN and SPLIT, holds in STOP, and is held at 0 in RESET. On the cycle it is at TICK_DIV-1 it wraps to 0, the count increments by 1 with decimal carry, and `tick` pulses.
- **Count wrap.** The count wraps from 10^DIGITS−1 to 0 and pulses `ovf` in the same cycle as `tick`. The count never holds a non-BCD digit.
- **Display.**
  - `frozen` is 1 only in SPLIT.
  - `display_bcd` shows the snapshot when `frozen` is 1, otherwise `count_bcd`.
  - The count keeps running underneath while in SPLIT.
- **STOP behaviour.** The display is live and static, because the count is halted.

## Timing
- **Button latency.** Once `btn[i]` rises on an armed button, the state, `led`, snapshot and `frozen` update on the 3rd rising edge (2 sync edges plus 1 register edge).
- **Registered outputs.** All outputs are registered; there is no combinational path from `btn` to outputs.
- **First tick.** When RUN is entered from RESET, the first `tick` occurs TICK_DIV cycles after the edge that sets RUN.
- **Resume from STOP.** The prescaler resumes from its held value, so partial intervals are kept.
- **Split capture.** The snapshot takes the count value present before that edge's increment. If a split capture and a tick coincide, the snapshot gets the old value.
- **Reset mid-operation.** Asserting `rst` clears everything immediately and asynchronously. Deassertion is synchronized externally; the first active edge after release sees state RESET.
- **Overlapping reset.** A reset event coinciding with a tick suppresses both `tick` and `ovf`.

## Configuration
- **`STOPWATCH_SPLIT_EN` defined.** Split function as described above.
- **`STOPWATCH_SPLIT_EN` not defined:**
  - The `btn[1]` debouncer and the snapshot register are not built.
  - The SPLIT state is unreachable.
  - `frozen` is tied to 0 and `display_bcd` equals `count_bcd`.
  - `led[1]` is tied to 0.

## Test plan
Bench parameters: TICK_DIV=4, DIGITS=2, DEB_CYCLES=3.
- **Reset values.** Assert `rst` mid-run → on the same cycle, `led=1000` and `count_bcd=0x00`; `tick=0` while held.
- **Start and count.** Press `btn[2]` for 5 cycles, then release → RUN 3 edges later. `tick` every 4 cycles; after 10 ticks, `count_bcd=0x10`.
- **Wrap.** Run to 0x99 → the next tick gives 0x00 with `ovf=1` for exactly one cycle.
- **Split.**
  - Split at count 0x23 → `frozen=1`, `display_bcd=0x23` while `count_bcd` advances.
  - A second split at 0x27 → display shows 0x27.
  - Start → `frozen=0` and the display is live.
- **Debounce and priority.**
  - A 2-cycle press of `btn[0]` → no event.
  - `btn[3]` and `btn[0]` released on the same cycle → RESET.
- **Stop and resume.** Stop with the prescaler at 2 → count holds. Start → the next tick comes 2 cycles after RUN.
